// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
// Shared ISA constants for the CPU control path: opcode / extension fields used
// to recognise branch-class instructions, condition-code encodings and the bit
// positions of each flag in the 5-bit flag vector {C,L,F,Z,N}.
// Also provides a small decode helper that classifies an instruction word by
// how it affects the program counter.
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] OP_EXT4   = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_C = 4;

    typedef enum logic [1:0] {
        KIND_SEQ   = 2'd0,
        KIND_BCOND = 2'd1,
        KIND_JCOND = 2'd2,
        KIND_JAL   = 2'd3
    } pc_kind_e;

    function automatic pc_kind_e decode_pc_kind(input logic [15:0] instr);
        pc_kind_e kind;
        kind = KIND_SEQ;
        if (instr[15:12] == OP_BCOND) begin
            kind = KIND_BCOND;
        end else if (instr[15:12] == OP_EXT4) begin
            if (instr[7:4] == EXT_JCOND) begin
                kind = KIND_JCOND;
            end else if (instr[7:4] == EXT_JAL) begin
                kind = KIND_JAL;
            end
        end
        return kind;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Combinational branch-condition evaluator.
// Ports:
//   cond  [3:0]  condition code from instruction[11:8]
//   flags [4:0]  {C,L,F,Z,N}
//   take         1 when the condition holds for the given flags
// -----------------------------------------------------------------------------
module cond_eval
    import cpu_isa_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       take
);

    logic f_c, f_l, f_f, f_z, f_n;

    assign f_c = flags[FLAG_C];
    assign f_l = flags[FLAG_L];
    assign f_f = flags[FLAG_F];
    assign f_z = flags[FLAG_Z];
    assign f_n = flags[FLAG_N];

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = f_z;
            COND_NE: take = ~f_z;
            COND_CS: take = f_c;
            COND_CC: take = ~f_c;
            COND_HI: take = f_l;
            COND_LS: take = ~f_l;
            COND_GT: take = f_n;
            COND_LE: take = ~f_n;
            COND_FS: take = f_f;
            COND_FC: take = ~f_f;
            COND_LO: take = ~f_l & ~f_z;
            COND_HS: take = f_l | f_z;
            COND_LT: take = ~f_n & ~f_z;
            COND_GE: take = f_n | f_z;
            COND_UC: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
// Program-counter stage behind the CPU control FSM. On each PC_enable strobe it
// commits the current instruction and selects the next pc: sequential, Bcond
// displacement, Jcond register target or JAL register target (with link).
// Ports:
//   clk, rst        clock (rising edge) and async active-low reset
//   PC_enable       commit strobe from the control FSM
//   instruction     current instruction word
//   flags           {C,L,F,Z,N}
//   rtarget         register-file read of Rtarget
//   pc              current instruction address (registered)
//   link_value      return address captured by JAL
//   link_we         one-cycle pulse after a JAL commit
//   branch_taken    one-cycle pulse after a redirecting commit
//   retired_count   commits since reset (wrapping)
// -----------------------------------------------------------------------------
module pc_branch_unit
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_enable,
    input  logic [15:0]       instruction,
    input  logic [4:0]        flags,
    input  logic [ADDR_W-1:0] rtarget,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_value,
    output logic              link_we,
    output logic              branch_taken,
    output logic [CNT_W-1:0]  retired_count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_q, link_d;
    logic              link_we_q, link_we_d;
    logic              taken_q, taken_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cond_take;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] disp_ext;
    pc_kind_e          kind;

    cond_eval u_cond_eval (
        .cond  (instruction[11:8]),
        .flags (flags),
        .take  (cond_take)
    );

    assign kind     = decode_pc_kind(instruction);
    assign pc_seq   = pc_q + 1'b1;
    assign disp_ext = {{(ADDR_W-8){instruction[7]}}, instruction[7:0]};

    // Pulses default low so they last exactly one cycle after the commit.
    always_comb begin
        pc_d      = pc_q;
        link_d    = link_q;
        link_we_d = 1'b0;
        taken_d   = 1'b0;
        cnt_d     = cnt_q;
        if (PC_enable) begin
            cnt_d = cnt_q + 1'b1;
            pc_d  = pc_seq;
            case (kind)
                KIND_BCOND: begin
                    if (cond_take) begin
                        pc_d    = pc_q + disp_ext;
                        taken_d = 1'b1;
                    end
                end
                KIND_JCOND: begin
                    if (cond_take) begin
                        pc_d    = rtarget;
                        taken_d = 1'b1;
                    end
                end
                KIND_JAL: begin
                    pc_d      = rtarget;
                    link_d    = pc_seq;
                    link_we_d = 1'b1;
                    taken_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            link_q    <= '0;
            link_we_q <= 1'b0;
            taken_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            link_q    <= link_d;
            link_we_q <= link_we_d;
            taken_q   <= taken_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pc            = pc_q;
    assign link_value    = link_q;
    assign link_we       = link_we_q;
    assign branch_taken  = taken_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_unit
// Self-checking bench: directed scenarios plus randomized commits compared
// against a behavioural model of the pc stage.
// -----------------------------------------------------------------------------
module tb_pc_branch_unit;

    logic        clk;
    logic        rst;
    logic        PC_enable;
    logic [15:0] instruction;
    logic [4:0]  flags;
    logic [15:0] rtarget;
    logic [15:0] pc;
    logic [15:0] link_value;
    logic        link_we;
    logic        branch_taken;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int          m_pc;
    int          m_link;
    bit          m_we;
    bit          m_taken;
    logic [31:0] m_cnt;

    pc_branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .PC_enable     (PC_enable),
        .instruction   (instruction),
        .flags         (flags),
        .rtarget       (rtarget),
        .pc            (pc),
        .link_value    (link_value),
        .link_we       (link_we),
        .branch_taken  (branch_taken),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Condition truth table written from the ISA description.
    function automatic bit cond_true(input int c, input logic [4:0] f);
        bit C, L, F, Z, N;
        C = f[4]; L = f[3]; F = f[2]; Z = f[1]; N = f[0];
        case (c)
            0:  return Z;
            1:  return !Z;
            2:  return C;
            3:  return !C;
            4:  return L;
            5:  return !L;
            6:  return N;
            7:  return !N;
            8:  return F;
            9:  return !F;
            10: return !L && !Z;
            11: return L || Z;
            12: return !N && !Z;
            13: return N || Z;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_link = 0; m_we = 0; m_taken = 0; m_cnt = '0;
    endtask

    task automatic model_commit(input logic [15:0] ins, input logic [4:0] f, input logic [15:0] rt);
        int op, ext, c, disp, seq;
        op   = int'(ins[15:12]);
        ext  = int'(ins[7:4]);
        c    = int'(ins[11:8]);
        disp = int'($signed(ins[7:0]));
        seq  = (m_pc + 1) % 65536;
        m_we = 0;
        m_taken = 0;
        if (op == 12) begin
            if (cond_true(c, f)) begin
                m_pc = (m_pc + disp) & 32'hFFFF;
                m_taken = 1;
            end else m_pc = seq;
        end else if (op == 4 && ext == 12) begin
            if (cond_true(c, f)) begin
                m_pc = int'(rt);
                m_taken = 1;
            end else m_pc = seq;
        end else if (op == 4 && ext == 8) begin
            m_link  = seq;
            m_pc    = int'(rt);
            m_we    = 1;
            m_taken = 1;
        end else begin
            m_pc = seq;
        end
        m_cnt = m_cnt + 1;
    endtask

    // One commit: drive at negedge, commit at posedge, return #1 after it.
    task automatic step(input logic [15:0] ins, input logic [4:0] f, input logic [15:0] rt);
        @(negedge clk);
        instruction = ins;
        flags       = f;
        rtarget     = rt;
        PC_enable   = 1'b1;
        @(posedge clk);
        #1;
        PC_enable = 1'b0;
        model_commit(ins, f, rt);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        m_we = 0;
        m_taken = 0;
    endtask

    task automatic jump_to(input logic [15:0] addr);
        step(16'h4EC0, 5'b00000, addr);
    endtask

    task automatic test_reset();
        if (pc !== 16'h0000 || retired_count !== 32'd0 || link_value !== 16'h0000
            || link_we !== 1'b0 || branch_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state pc=%h cnt=%0d link=%h we=%b bt=%b exp all zero",
                     pc, retired_count, link_value, link_we, branch_taken);
        end
        n_checks++;
    endtask

    task automatic test_rtype();
        step(16'h0125, 5'b11111, 16'hBEEF);
        if (pc !== 16'h0001 || branch_taken !== 1'b0 || retired_count !== 32'd1) begin
            n_err++;
            $display("FAIL rtype_first pc=%h bt=%b cnt=%0d exp 0001 0 1", pc, branch_taken, retired_count);
        end
        n_checks++;
        jump_to(16'h0010);
        step(16'h0125, 5'b00000, 16'h0000);
        if (pc !== 16'h0011 || branch_taken !== 1'b0 || retired_count !== m_cnt) begin
            n_err++;
            $display("FAIL rtype_0010 pc=%h bt=%b cnt=%0d exp 0011 0 %0d", pc, branch_taken, retired_count, m_cnt);
        end
        n_checks++;
    endtask

    task automatic test_bcond();
        jump_to(16'h0010);
        step(16'hC0FC, 5'b00010, 16'h0000);
        if (pc !== 16'h000C || branch_taken !== 1'b1) begin
            n_err++;
            $display("FAIL bcond_eq_taken pc=%h bt=%b exp 000c 1", pc, branch_taken);
        end
        n_checks++;
        jump_to(16'h0010);
        step(16'hC0FC, 5'b11101, 16'h0000);
        if (pc !== 16'h0011 || branch_taken !== 1'b0) begin
            n_err++;
            $display("FAIL bcond_eq_not pc=%h bt=%b exp 0011 0", pc, branch_taken);
        end
        n_checks++;
        // negative displacement below zero wraps high
        jump_to(16'h0002);
        step(16'hCEF0, 5'b00000, 16'h0000);
        if (pc !== 16'hFFF2) begin
            n_err++;
            $display("FAIL bcond_wrap pc=%h exp fff2", pc);
        end
        n_checks++;
    endtask

    task automatic test_jcond();
        step(16'h4EC3, 5'b00000, 16'h1234);
        if (pc !== 16'h1234 || branch_taken !== 1'b1) begin
            n_err++;
            $display("FAIL jcond_uc pc=%h bt=%b exp 1234 1", pc, branch_taken);
        end
        n_checks++;
        step(16'h4FC3, 5'b11111, 16'h5555);
        if (pc !== 16'h1235 || branch_taken !== 1'b0) begin
            n_err++;
            $display("FAIL jcond_never pc=%h bt=%b exp 1235 0", pc, branch_taken);
        end
        n_checks++;
    endtask

    task automatic test_jal();
        jump_to(16'h0020);
        step(16'h4A83, 5'b00000, 16'h0100);
        if (pc !== 16'h0100 || link_value !== 16'h0021 || link_we !== 1'b1 || branch_taken !== 1'b1) begin
            n_err++;
            $display("FAIL jal_commit pc=%h link=%h we=%b bt=%b exp 0100 0021 1 1",
                     pc, link_value, link_we, branch_taken);
        end
        n_checks++;
        idle();
        if (link_we !== 1'b0 || branch_taken !== 1'b0 || link_value !== 16'h0021 || pc !== 16'h0100) begin
            n_err++;
            $display("FAIL jal_pulse_end we=%b bt=%b link=%h pc=%h exp 0 0 0021 0100",
                     link_we, branch_taken, link_value, pc);
        end
        n_checks++;
    endtask

    task automatic test_wrap_hold();
        logic [31:0] cnt_before;
        jump_to(16'hFFFF);
        step(16'h0000, 5'b00000, 16'h0000);
        if (pc !== 16'h0000) begin
            n_err++;
            $display("FAIL pc_wrap pc=%h exp 0000", pc);
        end
        n_checks++;
        cnt_before = m_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            flags       = 5'($urandom);
            rtarget     = 16'($urandom);
            instruction = 16'h4EC0;
            idle();
        end
        if (pc !== 16'h0000 || retired_count !== cnt_before || branch_taken !== 1'b0) begin
            n_err++;
            $display("FAIL hold pc=%h cnt=%0d bt=%b exp 0000 %0d 0", pc, retired_count, branch_taken, cnt_before);
        end
        n_checks++;
    endtask

    task automatic test_async_reset();
        jump_to(16'h0030);
        step(16'h4A83, 5'b00000, 16'h0042);
        @(negedge clk);
        instruction = 16'h4EC0;
        rtarget     = 16'h7777;
        PC_enable   = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        if (pc !== 16'h0000 || retired_count !== 32'd0 || link_value !== 16'h0000
            || link_we !== 1'b0 || branch_taken !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset pc=%h cnt=%0d link=%h we=%b bt=%b exp all zero",
                     pc, retired_count, link_value, link_we, branch_taken);
        end
        n_checks++;
        @(posedge clk);
        #1;
        if (pc !== 16'h0000 || retired_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hold pc=%h cnt=%0d exp 0000 0", pc, retired_count);
        end
        n_checks++;
        PC_enable = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [3:0]  op;
        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0: op = 4'hC;
                1: begin op = 4'h4; ins[7:4] = 4'hC; end
                2: begin op = 4'h4; ins[7:4] = 4'h8; end
                default: op = ins[15:12];
            endcase
            ins[15:12] = op;
            step(ins, 5'($urandom), 16'($urandom));
            if (int'(pc) != m_pc || int'(link_value) != m_link || link_we !== m_we
                || branch_taken !== m_taken || retired_count !== m_cnt) begin
                n_err++;
                $display("FAIL random[%0d] ins=%h pc=%h/%h link=%h/%h we=%b/%b bt=%b/%b cnt=%0d/%0d",
                         i, ins, pc, m_pc[15:0], link_value, m_link[15:0], link_we, m_we,
                         branch_taken, m_taken, retired_count, m_cnt);
            end
            n_checks++;
            if ($urandom_range(0, 4) == 0) begin
                idle();
                if (link_we !== 1'b0 || branch_taken !== 1'b0 || int'(pc) != m_pc) begin
                    n_err++;
                    $display("FAIL random_idle[%0d] we=%b bt=%b pc=%h exp 0 0 %h",
                             i, link_we, branch_taken, pc, m_pc[15:0]);
                end
                n_checks++;
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        PC_enable   = 1'b0;
        instruction = 16'h0000;
        flags       = 5'b00000;
        rtarget     = 16'h0000;
        model_reset();
        #23;
        rst = 1'b1;
        test_reset();
        test_rtype();
        test_bcond();
        test_jcond();
        test_jal();
        test_wrap_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
